// File: rtl/fp_mul_pipe_pkg.sv
// Package fp_pkg: shared types and constant helpers for the pipelined FP multiplier.
//   fp_class_t  operand classification (subnormals are classified as zero)
//   fp_flags_t  special-case flags carried down the pipe per lane
//   fp_bias / fp_max_exp / fp_qnan  derived from EXPONENT and MANTISSA widths
package fp_pkg;
  typedef enum logic [1:0] {FP_NORMAL, FP_ZERO, FP_INF, FP_NAN} fp_class_t;

  typedef struct packed {
    logic nan;   // NaN operand, or inf*zero
    logic inf;   // at least one infinite operand
    logic zero;  // at least one zero operand
  } fp_flags_t;

  localparam int STAGES = 3;

  function automatic int fp_bias(int e);
    return (1 << (e - 1)) - 1;
  endfunction

  function automatic int fp_max_exp(int e);
    return (1 << e) - 1;
  endfunction

  // canonical quiet NaN: sign 0, exponent all ones, fraction MSB set
  function automatic logic [63:0] fp_qnan(int e, int m);
    return (((64'd1 << e) - 64'd1) << m) | (64'd1 << (m - 1));
  endfunction
endpackage

// File: rtl/fp_mul_pipe_if.sv
// Handshake/data bundle for fp_mul_pipe.
//   slave  : the multiplier side (consumes A/B/in_tag, produces OUT/out_tag)
//   master : the producer/consumer side
// Lane i of A/B/OUT is element [i], identical to the flat [i*W +: W] packing.
interface fp_mul_pipe_if #(
  parameter int LANES = 4,
  parameter int W     = 16,
  parameter int TAG_W = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES-1:0][W-1:0]    A;
  logic [LANES-1:0][W-1:0]    B;
  logic [TAG_W-1:0]           in_tag;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES-1:0][W-1:0]    OUT;
  logic [TAG_W-1:0]           out_tag;

  modport slave  (input  in_valid, A, B, in_tag, out_ready,
                  output in_ready, out_valid, OUT, out_tag);
  modport master (output in_valid, A, B, in_tag, out_ready,
                  input  in_ready, out_valid, OUT, out_tag);
endinterface

// File: rtl/fp_mul_pipe_lane.sv
// fp_mul_lane: one lane's 3-stage multiply datapath; every register is
// enabled by adv so the whole lane freezes on a stall.
//   clk, reset : clock, async active-high reset (clears all stage data)
//   adv        : pipeline advance
//   a, b       : operands {sign, exponent, fraction}
//   res        : registered product (S3 output)
// Macro FP_MUL_ROUND_EN selects round-to-nearest-even; otherwise truncate.
module fp_mul_lane
  import fp_pkg::*;
#(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       adv,
  input  logic [EXPONENT+MANTISSA:0] a,
  input  logic [EXPONENT+MANTISSA:0] b,
  output logic [EXPONENT+MANTISSA:0] res
);
  localparam int W  = 1 + EXPONENT + MANTISSA;
  localparam int PW = 2 * (MANTISSA + 1);
  localparam int EW = EXPONENT + 2;
  // truncation only needs the product bits that can land in the fraction
`ifdef FP_MUL_ROUND_EN
  localparam int KEEP = PW;
`else
  localparam int KEEP = MANTISSA + 2;
`endif
  localparam logic signed [EW-1:0] BIAS_E = EW'(fp_bias(EXPONENT));
  localparam logic signed [EW-1:0] MAX_E  = EW'(fp_max_exp(EXPONENT));
  localparam logic [W-1:0]         QNAN   = W'(fp_qnan(EXPONENT, MANTISSA));

  function automatic fp_class_t classify(logic [W-2:0] x);
    if (x[W-2:MANTISSA] == '0) return FP_ZERO;
    if (&x[W-2:MANTISSA]) return (x[MANTISSA-1:0] == '0) ? FP_INF : FP_NAN;
    return FP_NORMAL;
  endfunction

  fp_class_t             ca, cb;
  logic                  s1_sign_d, s1_sign_q, s2_sign_q;
  fp_flags_t             s1_flg_d, s1_flg_q, s2_flg_q;
  logic [KEEP-1:0]       s1_p_d, s1_p_q;
  logic signed [EW-1:0]  s1_e_d, s1_e_q, s2_e_d, s2_e_q;
  logic [MANTISSA-1:0]   s2_frac_d, s2_frac_q;
  logic [W-1:0]          res_d, res_q;
`ifdef FP_MUL_ROUND_EN
  logic                  guard, sticky;
  logic [MANTISSA:0]     rsum;
`endif

  // S1: classify, multiply significands, add exponents
  always_comb begin
    ca            = classify(a[W-2:0]);
    cb            = classify(b[W-2:0]);
    s1_sign_d     = a[W-1] ^ b[W-1];
    s1_flg_d.nan  = (ca == FP_NAN) || (cb == FP_NAN) ||
                    (ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF);
    s1_flg_d.inf  = (ca == FP_INF) || (cb == FP_INF);
    s1_flg_d.zero = (ca == FP_ZERO) || (cb == FP_ZERO);
    s1_p_d = KEEP'((PW'({1'b1, a[MANTISSA-1:0]}) * PW'({1'b1, b[MANTISSA-1:0]})) >> (PW - KEEP));
    s1_e_d = $signed(EW'(a[W-2:MANTISSA])) + $signed(EW'(b[W-2:MANTISSA])) - BIAS_E;
  end

  // S2: normalise (product is in [1,4)), then round
  always_comb begin
    if (s1_p_q[KEEP-1]) begin
      s2_frac_d = s1_p_q[KEEP-2 -: MANTISSA];
      s2_e_d    = s1_e_q + EW'(1);
    end else begin
      s2_frac_d = s1_p_q[KEEP-3 -: MANTISSA];
      s2_e_d    = s1_e_q;
    end
`ifdef FP_MUL_ROUND_EN
    guard  = s1_p_q[KEEP-1] ? s1_p_q[MANTISSA]          : s1_p_q[MANTISSA-1];
    sticky = s1_p_q[KEEP-1] ? |s1_p_q[MANTISSA-1:0]     : |s1_p_q[MANTISSA-2:0];
    rsum   = {1'b0, s2_frac_d} + (MANTISSA+1)'(guard && (sticky || s2_frac_d[0]));
    // carry out of the fraction leaves it zero and bumps the exponent
    if (rsum[MANTISSA]) s2_e_d = s2_e_d + EW'(1);
    s2_frac_d = rsum[MANTISSA-1:0];
`endif
  end

  // S3: special-case select and pack
  always_comb begin
    if (s2_flg_q.nan)                     res_d = QNAN;
    else if (s2_flg_q.inf)                res_d = {s2_sign_q, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
    else if (s2_flg_q.zero)               res_d = {s2_sign_q, {(W-1){1'b0}}};
    else if (s2_e_q >= MAX_E)             res_d = {s2_sign_q, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
    else if (s2_e_q[EW-1] || s2_e_q == '0) res_d = {s2_sign_q, {(W-1){1'b0}}};
    else                                  res_d = {s2_sign_q, s2_e_q[EXPONENT-1:0], s2_frac_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sign_q <= 1'b0;
      s1_flg_q  <= '0;
      s1_p_q    <= '0;
      s1_e_q    <= '0;
      s2_sign_q <= 1'b0;
      s2_flg_q  <= '0;
      s2_e_q    <= '0;
      s2_frac_q <= '0;
      res_q     <= '0;
    end else if (adv) begin
      s1_sign_q <= s1_sign_d;
      s1_flg_q  <= s1_flg_d;
      s1_p_q    <= s1_p_d;
      s1_e_q    <= s1_e_d;
      s2_sign_q <= s1_sign_q;
      s2_flg_q  <= s1_flg_q;
      s2_e_q    <= s2_e_d;
      s2_frac_q <= s2_frac_d;
      res_q     <= res_d;
    end
  end

  assign res = res_q;
endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: LANES-wide, 3-stage stallable floating-point multiplier.
//   clk, reset : clock, async active-high reset (drops all in-flight beats)
//   io (slave) : in_valid/in_ready/A/B/in_tag in, out_valid/out_ready/OUT/out_tag out
// The top owns only the valid chain, tag pipe and handshake; per-lane math is
// in fp_mul_lane. Macro FP_MUL_ROUND_EN enables round-to-nearest-even.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 7,
  parameter int LANES    = 4,
  parameter int TAG_W    = 4
) (
  input  logic          clk,
  input  logic          reset,
  fp_mul_pipe_if.slave  io
);
  logic                          adv, acc;
  logic [STAGES:1]               vld_pipe_d, vld_pipe_q;
  logic [STAGES:1][TAG_W-1:0]    tag_pipe_d, tag_pipe_q;

  // single global stall: everything moves only when the output slot frees
  assign adv = !vld_pipe_q[STAGES] || io.out_ready;
  assign acc = io.in_valid && adv;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    tag_pipe_d = tag_pipe_q;
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], acc};
      tag_pipe_d = {tag_pipe_q[STAGES-1:1], io.in_tag};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_mul_lane #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA)) u_lane (
      .clk   (clk),
      .reset (reset),
      .adv   (adv),
      .a     (io.A[i]),
      .b     (io.B[i]),
      .res   (io.OUT[i])
    );
  end

  assign io.in_ready  = adv;
  assign io.out_valid = vld_pipe_q[STAGES];
  assign io.out_tag   = tag_pipe_q[STAGES];
endmodule
